text_writer: RTL



---
 rtl/text_writer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/text_writer.sv
// Character RAM write-port feeder for the text display: takes a byte stream, keeps
// a wrapping text cursor and issues registered single-cycle writes into the RAM.
//
//  state    | meaning
//  ---------|---------------------------------------------------------------
//  ST_CLEAR | writing BLANK to every cell, one per cycle; input not accepted
//  ST_IDLE  | accepting bytes; printable/BS produce writes, CR/LF/FF move the cursor
module text_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 60,
    parameter int         ADDR_W = 13,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              px_clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic [6:0]        cur_col,
    output logic [5:0]        cur_row,
    output logic              busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
    localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [6:0]        col_q,      col_d;
    logic [5:0]        row_q,      row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [7:0]        wdata_q,    wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q,     busy_d;

    logic              accept;
    logic              printable;
    logic [ADDR_W-1:0] cur_addr;
    logic [5:0]        row_adv;
    logic [ADDR_W-1:0] row_base_adv;

    always_comb begin
        accept    = in_valid && in_ready_q && (state_q == ST_IDLE);
        printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
        cur_addr  = row_base_q + ADDR_W'(col_q);

        // row_base follows cur_row*COLS by adding COLS per row, wrapping to 0
        if (row_q == ROW_LAST) begin
            row_adv      = 6'd0;
            row_base_adv = '0;
        end else begin
            row_adv      = row_q + 6'd1;
            row_base_adv = row_base_q + COLS_A;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        write_en_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;

        case (state_q)
            ST_CLEAR: begin
                write_en_d = 1'b1;
                waddr_d    = clr_addr_q;
                wdata_d    = BLANK;
                col_d      = 7'd0;
                row_d      = 6'd0;
                row_base_d = '0;
                if (clr_addr_q == CLR_LAST) begin
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    if (printable) begin
                        write_en_d = 1'b1;
                        waddr_d    = cur_addr;
                        wdata_d    = in_data;
                        if (col_q == COL_LAST) begin
                            col_d      = 7'd0;
                            row_d      = row_adv;
                            row_base_d = row_base_adv;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (in_data)
                            CH_CR: col_d = 7'd0;
                            CH_LF: begin
                                row_d      = row_adv;
                                row_base_d = row_base_adv;
                            end
                            CH_BS: begin
                                // BS stops at column 0; it never backs into the previous row
                                if (col_q != 7'd0) begin
                                    col_d      = col_q - 7'd1;
                                    write_en_d = 1'b1;
                                    waddr_d    = cur_addr - ADDR_W'(1);
                                    wdata_d    = BLANK;
                                end
                            end
                            CH_FF: begin
                                col_d      = 7'd0;
                                row_d      = 6'd0;
                                row_base_d = '0;
                                state_d    = ST_CLEAR;
                                in_ready_d = 1'b0;
                                busy_d     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            col_q      <= 7'd0;
            row_q      <= 6'd0;
            row_base_q <= '0;
            write_en_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            write_en_q <= write_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign write_en = write_en_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;
    assign busy     = busy_q;

endmodule
